// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pong_pkg
//  Purpose : Shared definitions for the ping-pong game sequencer: FSM state
//            encoding, winner codes, default game constants and a 2-digit
//            BCD increment helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pong_pkg;

  // State encoding is also the value presented on the 'state' output port.
  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } game_state_t;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;

  localparam logic [7:0] DEF_WIN_SCORE        = 8'h05;
  localparam int         DEF_BALL_WAIT_FRAMES = 120;
  localparam int         DEF_OVER_WAIT_FRAMES = 300;
  localparam int         DEF_TMR_W            = 9;

  // {tens, units} + 1 in BCD; 99 wraps to 00.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] value);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = value[7:4];
    units = value[3:0];
    if (units >= 4'd9) begin
      units = 4'd0;
      tens  = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_counter.sv
`default_nettype none
// ============================================================================
//  Module  : bcd2_counter
//  Purpose : Two-digit BCD score counter with synchronous clear and
//            increment enable.
//  Ports   : clk, reset (async, active-high)
//            clr        - synchronous clear to 8'h00 (wins over inc)
//            inc        - increment by one on this edge
//            count      - current value {tens, units}
//            count_inc  - value the counter would take on an increment
//  Rev     : 1.0  initial release
// ============================================================================
module bcd2_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count,
  output logic [7:0] count_inc
);

  // Exposed so the controller can test the post-increment score against the
  // winning value in the same cycle the point is scored.
  assign count_inc = bcd2_inc(count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'h00;
    end else if (clr) begin
      count <= 8'h00;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : pong_game_ctrl
//  Purpose : Game-level sequencer for the ping-pong design. Runs the
//            NEWGAME / PLAY / NEWBALL / OVER state machine, keeps both BCD
//            scores, counts rally hits and freezes the ball between points.
//  Ports   : clk, reset (async, active-high)
//            frame_tick          - one-cycle pulse per video frame
//            btn[3:0]            - debounced paddle buttons (any starts a game)
//            l_hit, r_hit        - paddle hit levels from graphics
//            l_mis, r_mis        - miss levels from graphics
//            gra_still           - freeze and centre the ball
//            l_score, r_score    - BCD scores {tens, units}
//            rally               - hits in current rally, saturates at 255
//            state               - 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
//            winner              - 01 left, 10 right, 00 none
//            show_start, show_over - overlay text selects
//  Rev     : 1.0  initial release
// ============================================================================
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [7:0] WIN_SCORE        = DEF_WIN_SCORE,
  parameter int         BALL_WAIT_FRAMES = DEF_BALL_WAIT_FRAMES,
  parameter int         OVER_WAIT_FRAMES = DEF_OVER_WAIT_FRAMES,
  parameter int         TMR_W            = DEF_TMR_W
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [3:0] btn,
  input  logic       l_hit,
  input  logic       r_hit,
  input  logic       l_mis,
  input  logic       r_mis,
  output logic       gra_still,
  output logic [7:0] l_score,
  output logic [7:0] r_score,
  output logic [7:0] rally,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic       show_start,
  output logic       show_over
);

  localparam logic [TMR_W-1:0] BALL_LOAD = TMR_W'(BALL_WAIT_FRAMES - 1);
  localparam logic [TMR_W-1:0] OVER_LOAD = TMR_W'(OVER_WAIT_FRAMES - 1);

  game_state_t      cur_state;
  game_state_t      nxt_state;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic [7:0]       rally_nxt;
  logic [1:0]       winner_nxt;

  logic btn_any;
  logic btn_any_d;
  logic armed;
  logic start;
  logic hit_any;
  logic hit_d;
  logic hit_rise;

  logic       clr_scores;
  logic       inc_l;
  logic       inc_r;
  logic [7:0] l_score_inc;
  logic [7:0] r_score_inc;

  assign btn_any  = |btn;
  assign hit_any  = l_hit | r_hit;
  assign hit_rise = hit_any & ~hit_d;

  // 'armed' stays low after reset until all buttons have been seen released,
  // so a button held through reset release cannot masquerade as a fresh
  // press even though the delay flop itself resets to 0.
  assign start = btn_any & ~btn_any_d & armed;

  bcd2_counter u_l_score (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr_scores),
    .inc       (inc_l),
    .count     (l_score),
    .count_inc (l_score_inc)
  );

  bcd2_counter u_r_score (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr_scores),
    .inc       (inc_r),
    .count     (r_score),
    .count_inc (r_score_inc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_NEWGAME;
      timer     <= '0;
      rally     <= 8'd0;
      winner    <= WINNER_NONE;
      btn_any_d <= 1'b0;
      hit_d     <= 1'b0;
      armed     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      timer     <= timer_nxt;
      rally     <= rally_nxt;
      winner    <= winner_nxt;
      btn_any_d <= btn_any;
      hit_d     <= hit_any;
      armed     <= armed | ~btn_any;
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    timer_nxt  = timer;
    rally_nxt  = rally;
    winner_nxt = winner;
    clr_scores = 1'b0;
    inc_l      = 1'b0;
    inc_r      = 1'b0;

    unique case (cur_state)
      ST_NEWGAME: begin
        if (start) begin
          clr_scores = 1'b1;
          rally_nxt  = 8'd0;
          winner_nxt = WINNER_NONE;
          nxt_state  = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // A miss owns the cycle: l_mis first, and no rally increment alongside.
        if (l_mis) begin
          inc_r = 1'b1;
          if (r_score_inc == WIN_SCORE) begin
            winner_nxt = WINNER_RIGHT;
            timer_nxt  = OVER_LOAD;
            nxt_state  = ST_OVER;
          end else begin
            timer_nxt = BALL_LOAD;
            rally_nxt = 8'd0;
            nxt_state = ST_NEWBALL;
          end
        end else if (r_mis) begin
          inc_l = 1'b1;
          if (l_score_inc == WIN_SCORE) begin
            winner_nxt = WINNER_LEFT;
            timer_nxt  = OVER_LOAD;
            nxt_state  = ST_OVER;
          end else begin
            timer_nxt = BALL_LOAD;
            rally_nxt = 8'd0;
            nxt_state = ST_NEWBALL;
          end
        end else if (hit_rise && (rally != 8'hFF)) begin
          rally_nxt = rally + 8'd1;
        end
      end

      ST_NEWBALL: begin
        if (frame_tick) begin
          if (timer == '0) begin
            nxt_state = ST_PLAY;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (frame_tick) begin
          if (timer == '0) begin
            nxt_state = ST_NEWGAME;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
      end

      default: nxt_state = ST_NEWGAME;
    endcase
  end

  // Pure state decodes: a state change and its overlay/freeze effect appear
  // on the same edge.
  assign state      = cur_state;
  assign gra_still  = (cur_state != ST_PLAY);
  assign show_start = (cur_state == ST_NEWGAME);
  assign show_over  = (cur_state == ST_OVER);

endmodule
`default_nettype wire
